// File: rtl/adc_trig_decim_pkg.sv
// Shared types and widths for the ADC trigger/decimation front end.
// Sample word layout: ch0 in [11:0], ch1 in [27:16], other nibbles zero.
package adc_trig_decim_pkg;

    localparam int ADC_W            = 12;
    localparam int DEF_MAX_LOG2_DEC = 8;
    localparam int DEF_CNT_W        = 13;
    localparam int ADC_ACC_W        = ADC_W + DEF_MAX_LOG2_DEC;

    typedef enum logic [1:0] {
        TRIG_IMM  = 2'd0,
        TRIG_RISE = 2'd1,
        TRIG_FALL = 2'd2,
        TRIG_EXT  = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic [3:0]       pad1;
        logic [ADC_W-1:0] ch1;
        logic [3:0]       pad0;
        logic [ADC_W-1:0] ch0;
    } adc_sample_t;

endpackage

// File: rtl/adc_decim_ch.sv
// Per-channel window reducer: boxcar sum or first-sample capture.
// The result is combinational and valid on the window's last sample cycle.
module adc_decim_ch
    import adc_trig_decim_pkg::*;
#(
    parameter int ACC_W = ADC_ACC_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             start,
    input  logic             avg_en,
    input  logic [3:0]       dec,
    input  logic [ADC_W-1:0] raw,
    output logic [ADC_W-1:0] result
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [ADC_W-1:0] first;

    // The current sample is folded in so the last sample of a window counts.
    always_comb begin
        acc_next = start ? ACC_W'(raw) : acc + ACC_W'(raw);
        if (avg_en) begin
            result = ADC_W'(acc_next >> dec);
        end else if (start) begin
            result = raw;
        end else begin
            result = first;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            first <= '0;
        end else if (clr) begin
            acc   <= '0;
            first <= '0;
        end else if (en) begin
            acc <= acc_next;
            if (start) begin
                first <= raw;
            end
        end
    end

endmodule

// File: rtl/adc_trig_decim.sv
// Capture qualifier: arms on a CSR edge, waits for a trigger, then streams a
// fixed number of decimated or averaged two-channel samples.
module adc_trig_decim
    import adc_trig_decim_pkg::*;
#(
    parameter int MAX_LOG2_DEC = DEF_MAX_LOG2_DEC,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [ADC_W-1:0]  ad_data_ch0_i,
    input  logic [ADC_W-1:0]  ad_data_ch1_i,
    input  logic              arm_i,
    input  logic [1:0]        trig_mode_i,
    input  logic              trig_ch_i,
    input  logic [ADC_W-1:0]  trig_level_i,
    input  logic [ADC_W-1:0]  trig_hyst_i,
    input  logic              ext_trig_i,
    input  logic [3:0]        dec_log2_i,
    input  logic              avg_en_i,
    input  logic [CNT_W-1:0]  num_samples_i,
    output adc_sample_t       sample_o,
    output logic              sample_vld_o,
    output logic              trig_o,
    output logic              armed_o,
    output logic              done_o
);

    localparam int                      ACC_W   = ADC_W + MAX_LOG2_DEC;
    localparam logic [3:0]              DEC_MAX = 4'(MAX_LOG2_DEC);
    localparam logic [MAX_LOG2_DEC-1:0] WIN_ONE = {{(MAX_LOG2_DEC-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]        CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cap_state_e              state;
    trig_mode_e              mode_sh;
    logic                    arm_q, arm_edge;
    logic                    ch_sh, avg_sh, primed, fin_q;
    logic [ADC_W-1:0]        level_sh, hyst_sh, sel, lo_thr, hi_thr, res0, res1;
    logic [ADC_W:0]          hi_sum;
    logic [3:0]              dec_sh;
    logic [CNT_W-1:0]        num_sh, out_cnt;
    logic [MAX_LOG2_DEC-1:0] win_cnt, win_max;
    logic                    fire, prime_set, in_win, win_start, win_last;

    assign arm_edge = arm_i & ~arm_q;
    assign sel      = ch_sh ? ad_data_ch1_i : ad_data_ch0_i;
    assign lo_thr   = (level_sh > hyst_sh) ? level_sh - hyst_sh : '0;
    assign hi_sum   = {1'b0, level_sh} + {1'b0, hyst_sh};
    assign hi_thr   = hi_sum[ADC_W] ? {ADC_W{1'b1}} : hi_sum[ADC_W-1:0];
    assign win_max  = ~({MAX_LOG2_DEC{1'b1}} << dec_sh);

    // Priming looks only at the registered flag, so the priming sample never fires.
    always_comb begin
        fire      = 1'b0;
        prime_set = 1'b0;
        if (state == ST_ARMED && !arm_edge) begin
            case (mode_sh)
                TRIG_IMM:  fire = 1'b1;
                TRIG_RISE: begin
                    prime_set = sel < lo_thr;
                    fire      = primed && (sel >= level_sh);
                end
                TRIG_FALL: begin
                    prime_set = sel > hi_thr;
                    fire      = primed && (sel <= level_sh);
                end
                default:   fire = ext_trig_i;
            endcase
        end
    end

    assign in_win    = fire || (state == ST_STREAM && !fin_q && !arm_edge);
    assign win_start = in_win && (win_cnt == '0);
    assign win_last  = in_win && (win_cnt == win_max);

    adc_decim_ch #(.ACC_W(ACC_W)) u_ch0 (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(arm_edge), .en(in_win),
        .start(win_start), .avg_en(avg_sh), .dec(dec_sh),
        .raw(ad_data_ch0_i), .result(res0)
    );

    adc_decim_ch #(.ACC_W(ACC_W)) u_ch1 (
        .clk(sys_clk), .rst_n(sys_rst_n), .clr(arm_edge), .en(in_win),
        .start(win_start), .avg_en(avg_sh), .dec(dec_sh),
        .raw(ad_data_ch1_i), .result(res1)
    );

    // fin_q marks that the final strobe is on the output; DONE follows a cycle later.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state        <= ST_IDLE;
            arm_q        <= 1'b0;
            mode_sh      <= TRIG_IMM;
            ch_sh        <= 1'b0;
            level_sh     <= '0;
            hyst_sh      <= '0;
            dec_sh       <= '0;
            avg_sh       <= 1'b0;
            num_sh       <= '0;
            primed       <= 1'b0;
            fin_q        <= 1'b0;
            win_cnt      <= '0;
            out_cnt      <= '0;
            sample_o     <= '0;
            sample_vld_o <= 1'b0;
            trig_o       <= 1'b0;
            armed_o      <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            arm_q        <= arm_i;
            sample_vld_o <= 1'b0;
            trig_o       <= 1'b0;
            if (arm_edge) begin
                state    <= ST_ARMED;
                armed_o  <= 1'b1;
                done_o   <= 1'b0;
                primed   <= 1'b0;
                fin_q    <= 1'b0;
                win_cnt  <= '0;
                out_cnt  <= '0;
                mode_sh  <= trig_mode_e'(trig_mode_i);
                ch_sh    <= trig_ch_i;
                level_sh <= trig_level_i;
                hyst_sh  <= trig_hyst_i;
                dec_sh   <= (dec_log2_i > DEC_MAX) ? DEC_MAX : dec_log2_i;
                avg_sh   <= avg_en_i;
                num_sh   <= num_samples_i;
            end else begin
                case (state)
                    ST_ARMED: begin
                        if (prime_set) begin
                            primed <= 1'b1;
                        end
                        if (fire) begin
                            state   <= ST_STREAM;
                            armed_o <= 1'b0;
                            trig_o  <= 1'b1;
                        end
                    end
                    ST_STREAM: begin
                        if (fin_q) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                            fin_q  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
                if (in_win) begin
                    win_cnt <= win_last ? '0 : win_cnt + WIN_ONE;
                    if (win_last) begin
                        sample_vld_o <= 1'b1;
                        sample_o     <= '{pad1: 4'h0, ch1: res1, pad0: 4'h0, ch0: res0};
                        out_cnt      <= out_cnt + CNT_ONE;
                        if (out_cnt == num_sh - CNT_ONE) begin
                            fin_q <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_trig_decim.sv
// Self-checking bench for adc_trig_decim: random and directed captures compared
// cycle by cycle against a sample-array reference model of the capture rules.
module tb_adc_trig_decim;
    import adc_trig_decim_pkg::*;

    localparam int MAXC = 8400;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [11:0] ad_data_ch0_i, ad_data_ch1_i;
    logic        arm_i;
    logic [1:0]  trig_mode_i;
    logic        trig_ch_i;
    logic [11:0] trig_level_i, trig_hyst_i;
    logic        ext_trig_i;
    logic [3:0]  dec_log2_i;
    logic        avg_en_i;
    logic [12:0] num_samples_i;
    adc_sample_t sample_o;
    logic        sample_vld_o, trig_o, armed_o, done_o;

    int checks = 0;
    int errors = 0;

    int          stim0 [MAXC];
    int          stim1 [MAXC];
    bit          stimext [MAXC];
    bit          stimarm [MAXC];
    logic [31:0] obs_s [MAXC];
    logic        obs_vld [MAXC], obs_trig [MAXC], obs_armed [MAXC], obs_done [MAXC];
    int          exp_s0 [MAXC], exp_s1 [MAXC];
    bit          exp_vld [MAXC], exp_trig [MAXC], exp_armed [MAXC], exp_done [MAXC];

    int cfg_mode, cfg_ch, cfg_level, cfg_hyst, cfg_dec, cfg_avg, cfg_num;

    adc_trig_decim dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .ad_data_ch0_i(ad_data_ch0_i), .ad_data_ch1_i(ad_data_ch1_i),
        .arm_i(arm_i), .trig_mode_i(trig_mode_i), .trig_ch_i(trig_ch_i),
        .trig_level_i(trig_level_i), .trig_hyst_i(trig_hyst_i),
        .ext_trig_i(ext_trig_i), .dec_log2_i(dec_log2_i), .avg_en_i(avg_en_i),
        .num_samples_i(num_samples_i), .sample_o(sample_o),
        .sample_vld_o(sample_vld_o), .trig_o(trig_o), .armed_o(armed_o),
        .done_o(done_o)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic do_reset();
        sys_rst_n = 1'b0;
        arm_i = 1'b0; ext_trig_i = 1'b0;
        ad_data_ch0_i = '0; ad_data_ch1_i = '0;
        trig_mode_i = '0; trig_ch_i = 1'b0; trig_level_i = '0; trig_hyst_i = '0;
        dec_log2_i = '0; avg_en_i = 1'b0; num_samples_i = '0;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic prep();
        for (int c = 0; c < MAXC; c++) begin
            stim0[c] = $urandom_range(0, 4095);
            stim1[c] = $urandom_range(0, 4095);
            stimext[c] = ($urandom_range(0, 15) == 0);
            stimarm[c] = 1'b0;
            exp_vld[c] = 1'b0; exp_trig[c] = 1'b0;
            exp_armed[c] = 1'b0; exp_done[c] = 1'b0;
            exp_s0[c] = 0; exp_s1[c] = 0;
        end
    endtask

    task automatic arm_at(input int a);
        for (int c = a; c < MAXC; c++) stimarm[c] = 1'b1;
    endtask

    // Outputs sampled at the negedge are the values for cycle c; inputs then apply to cycle c.
    task automatic run(input int len);
        trig_mode_i   = 2'(cfg_mode);
        trig_ch_i     = 1'(cfg_ch);
        trig_level_i  = 12'(cfg_level);
        trig_hyst_i   = 12'(cfg_hyst);
        dec_log2_i    = 4'(cfg_dec);
        avg_en_i      = 1'(cfg_avg);
        num_samples_i = 13'(cfg_num);
        for (int c = 0; c < len; c++) begin
            obs_s[c] = sample_o; obs_vld[c] = sample_vld_o; obs_trig[c] = trig_o;
            obs_armed[c] = armed_o; obs_done[c] = done_o;
            ad_data_ch0_i = 12'(stim0[c]);
            ad_data_ch1_i = 12'(stim1[c]);
            arm_i = stimarm[c];
            ext_trig_i = stimext[c];
            @(negedge sys_clk);
        end
    endtask

    // Capture armed by an edge at cycle a; its visible outputs end at cycle stop.
    function automatic int model_capture(input int a, input int stop);
        int n, d, num, lo, hi, t, s, oc, sum0, sum1;
        bit primed;
        d   = (cfg_dec > 8) ? 8 : cfg_dec;
        n   = 1 << d;
        num = (cfg_num == 0) ? 8192 : cfg_num;
        lo  = (cfg_level - cfg_hyst < 0) ? 0 : cfg_level - cfg_hyst;
        hi  = (cfg_level + cfg_hyst > 4095) ? 4095 : cfg_level + cfg_hyst;
        t = -1; primed = 1'b0;
        for (int c = a + 1; c < stop; c++) begin
            s = cfg_ch ? stim1[c] : stim0[c];
            if (cfg_mode == 0) t = c;
            else if (cfg_mode == 1) begin
                if (primed && s >= cfg_level) t = c;
                else if (s < lo) primed = 1'b1;
            end else if (cfg_mode == 2) begin
                if (primed && s <= cfg_level) t = c;
                else if (s > hi) primed = 1'b1;
            end else if (stimext[c]) t = c;
            if (t >= 0) break;
        end
        for (int c = a + 1; c <= ((t < 0) ? stop : t); c++) exp_armed[c] = 1'b1;
        if (t >= 0) begin
            if (t + 1 <= stop) exp_trig[t + 1] = 1'b1;
            for (int k = 0; k < num; k++) begin
                oc = t + k * n + n;
                if (oc > stop) break;
                sum0 = 0; sum1 = 0;
                for (int j = 0; j < n; j++) begin
                    sum0 += stim0[t + k * n + j];
                    sum1 += stim1[t + k * n + j];
                end
                exp_vld[oc] = 1'b1;
                exp_s0[oc] = cfg_avg ? (sum0 >> d) : stim0[t + k * n];
                exp_s1[oc] = cfg_avg ? (sum1 >> d) : stim1[t + k * n];
            end
            for (int c = t + num * n + 1; c <= stop; c++) exp_done[c] = 1'b1;
        end
        return t;
    endfunction

    task automatic test_reset();
        do_reset();
        checks++;
        if (sample_vld_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_vld got %b want 0", sample_vld_o); end
        checks++;
        if (trig_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig got %b want 0", trig_o); end
        checks++;
        if (armed_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_armed got %b want 0", armed_o); end
        checks++;
        if (done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done_o); end
        checks++;
        if (sample_o !== 32'h0) begin errors++; $display("[TB] FAIL reset_sample got %h want 0", sample_o); end
    endtask

    task automatic test_immediate();
        int len, a, t;
        logic [31:0] hold;
        do_reset(); prep();
        a = 2; len = 14;
        cfg_mode = 0; cfg_ch = 0; cfg_level = 0; cfg_hyst = 0; cfg_dec = 0; cfg_avg = 0; cfg_num = 4;
        for (int i = 0; i < 10; i++) stim0[a + 1 + i] = 100 + i;
        arm_at(a);
        t = model_capture(a, len - 1);
        run(len);
        hold = '0;
        for (int c = 0; c < len; c++) begin
            if (exp_vld[c]) hold = {4'h0, 12'(exp_s1[c]), 4'h0, 12'(exp_s0[c])};
            checks++;
            if ({obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c]} !== {exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c]} || obs_s[c] !== hold) begin
                errors++;
                $display("[TB] FAIL imm cyc %0d vtad=%b%b%b%b smp=%h wanted vtad=%b%b%b%b smp=%h", c, obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c], obs_s[c], exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c], hold);
            end
        end
        checks++;
        if (t != a + 1 || obs_trig[a + 2] !== 1'b1) begin errors++; $display("[TB] FAIL imm_trig got trig=%b want 1 at cycle %0d", obs_trig[a + 2], a + 2); end
        checks++;
        if (obs_s[a + 2][11:0] !== 12'd100 || obs_s[a + 5][11:0] !== 12'd103) begin
            errors++; $display("[TB] FAIL imm_ramp got %0d..%0d want 100..103", obs_s[a + 2][11:0], obs_s[a + 5][11:0]);
        end
        checks++;
        if (obs_done[a + 6] !== 1'b1 || obs_vld[a + 6] !== 1'b0) begin
            errors++; $display("[TB] FAIL imm_done got done=%b vld=%b want 1 0", obs_done[a + 6], obs_vld[a + 6]);
        end
    endtask

    task automatic test_rise();
        int len, a, t;
        int seq [5] = '{2040, 2050, 2020, 2047, 2048};
        logic [31:0] hold;
        do_reset(); prep();
        a = 2; len = 20;
        cfg_mode = 1; cfg_ch = 1; cfg_level = 2048; cfg_hyst = 16; cfg_dec = 0; cfg_avg = 0; cfg_num = 3;
        for (int i = 0; i < 5; i++) stim1[a + 1 + i] = seq[i];
        arm_at(a);
        t = model_capture(a, len - 1);
        run(len);
        hold = '0;
        for (int c = 0; c < len; c++) begin
            if (exp_vld[c]) hold = {4'h0, 12'(exp_s1[c]), 4'h0, 12'(exp_s0[c])};
            checks++;
            if ({obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c]} !== {exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c]} || obs_s[c] !== hold) begin
                errors++;
                $display("[TB] FAIL rise cyc %0d vtad=%b%b%b%b smp=%h wanted vtad=%b%b%b%b smp=%h", c, obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c], obs_s[c], exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c], hold);
            end
        end
        checks++;
        if (t != a + 5 || obs_trig[a + 6] !== 1'b1 || obs_trig[a + 3] !== 1'b0) begin
            errors++; $display("[TB] FAIL rise_fire got trig@2050=%b trig@2048=%b want 0 1", obs_trig[a + 3], obs_trig[a + 6]);
        end
        checks++;
        if (obs_vld[a + 6] !== 1'b1 || obs_s[a + 6][27:16] !== 12'd2048) begin
            errors++; $display("[TB] FAIL rise_first got vld=%b ch1=%0d want 1 2048", obs_vld[a + 6], obs_s[a + 6][27:16]);
        end
    endtask

    task automatic test_average();
        int len, a, t;
        int seq [8] = '{10, 11, 12, 13, 20, 20, 20, 20};
        logic [31:0] hold;
        for (int av = 1; av >= 0; av--) begin
            do_reset(); prep();
            a = 2; len = 18;
            cfg_mode = 0; cfg_ch = 0; cfg_level = 0; cfg_hyst = 0; cfg_dec = 2; cfg_avg = av; cfg_num = 2;
            for (int i = 0; i < 8; i++) stim0[a + 1 + i] = seq[i];
            arm_at(a);
            t = model_capture(a, len - 1);
            run(len);
            hold = '0;
            for (int c = 0; c < len; c++) begin
                if (exp_vld[c]) hold = {4'h0, 12'(exp_s1[c]), 4'h0, 12'(exp_s0[c])};
                checks++;
                if ({obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c]} !== {exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c]} || obs_s[c] !== hold) begin
                    errors++;
                    $display("[TB] FAIL avg%0d cyc %0d vtad=%b%b%b%b smp=%h wanted vtad=%b%b%b%b smp=%h", av, c, obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c], obs_s[c], exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c], hold);
                end
            end
            checks++;
            if (t != a + 1 || obs_vld[a + 5] !== 1'b1 || obs_vld[a + 9] !== 1'b1 ||
                obs_s[a + 5][11:0] !== (av ? 12'd11 : 12'd10) || obs_s[a + 9][11:0] !== 12'd20) begin
                errors++;
                $display("[TB] FAIL avg%0d_values got %0d,%0d want %0d,20", av, obs_s[a + 5][11:0], obs_s[a + 9][11:0], av ? 11 : 10);
            end
        end
    endtask

    task automatic test_fall();
        int len, a, t;
        logic [31:0] hold;
        do_reset(); prep();
        a = 2; len = 80;
        cfg_mode = 2; cfg_ch = 0; cfg_level = 4090; cfg_hyst = 100; cfg_dec = 0; cfg_avg = 0; cfg_num = 2;
        for (int i = 0; i < 70; i += 2) begin stim0[a + 1 + i] = 4095; stim0[a + 2 + i] = 10; end
        arm_at(a);
        t = model_capture(a, len - 1);
        run(len);
        hold = '0;
        for (int c = 0; c < len; c++) begin
            checks++;
            if ({obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c]} !== {exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c]} || obs_s[c] !== hold) begin
                errors++;
                $display("[TB] FAIL fall_sat cyc %0d vtad=%b%b%b%b smp=%h wanted vtad=%b%b%b%b smp=%h", c, obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c], obs_s[c], exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c], hold);
            end
        end
        checks++;
        if (t != -1 || obs_armed[len - 1] !== 1'b1) begin errors++; $display("[TB] FAIL fall_sat_armed got %b want 1", obs_armed[len - 1]); end

        do_reset(); prep();
        len = 16;
        cfg_level = 100; cfg_hyst = 200;
        stim0[a + 1] = 400; stim0[a + 2] = 150; stim0[a + 3] = 90;
        arm_at(a);
        t = model_capture(a, len - 1);
        run(len);
        for (int c = 0; c < len; c++) begin
            if (exp_vld[c]) hold = {4'h0, 12'(exp_s1[c]), 4'h0, 12'(exp_s0[c])};
            checks++;
            if ({obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c]} !== {exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c]} || obs_s[c] !== hold) begin
                errors++;
                $display("[TB] FAIL fall cyc %0d vtad=%b%b%b%b smp=%h wanted vtad=%b%b%b%b smp=%h", c, obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c], obs_s[c], exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c], hold);
            end
        end
        checks++;
        if (t != a + 3 || obs_trig[a + 4] !== 1'b1 || obs_s[a + 4][11:0] !== 12'd90) begin
            errors++; $display("[TB] FAIL fall_fire got trig=%b ch0=%0d want 1 90", obs_trig[a + 4], obs_s[a + 4][11:0]);
        end
    endtask

    task automatic test_back_to_back();
        int len, a, b, t;
        logic [31:0] hold;
        do_reset(); prep();
        a = 2; b = 10; len = 40;
        cfg_mode = 0; cfg_ch = 0; cfg_level = 0; cfg_hyst = 0; cfg_dec = 1; cfg_avg = 1; cfg_num = 8;
        arm_at(a);
        stimarm[b - 1] = 1'b0;
        t = model_capture(a, b);
        t = model_capture(b, len - 1);
        run(len);
        hold = '0;
        for (int c = 0; c < len; c++) begin
            if (exp_vld[c]) hold = {4'h0, 12'(exp_s1[c]), 4'h0, 12'(exp_s0[c])};
            checks++;
            if ({obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c]} !== {exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c]} || obs_s[c] !== hold) begin
                errors++;
                $display("[TB] FAIL rearm cyc %0d vtad=%b%b%b%b smp=%h wanted vtad=%b%b%b%b smp=%h", c, obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c], obs_s[c], exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c], hold);
            end
        end
        checks++;
        if (obs_vld[b + 1] !== 1'b0 || obs_armed[b + 1] !== 1'b1) begin
            errors++; $display("[TB] FAIL rearm_abort got vld=%b armed=%b want 0 1", obs_vld[b + 1], obs_armed[b + 1]);
        end
    endtask

    task automatic test_wrap();
        int len, a, t, strobes;
        do_reset(); prep();
        a = 2; len = 8200;
        cfg_mode = 0; cfg_ch = 0; cfg_level = 0; cfg_hyst = 0; cfg_dec = 0; cfg_avg = 0; cfg_num = 0;
        arm_at(a);
        t = model_capture(a, len - 1);
        run(len);
        strobes = 0;
        for (int c = 0; c < len; c++) begin
            if (obs_vld[c] === 1'b1) strobes++;
            checks++;
            if ({obs_vld[c], obs_done[c]} !== {exp_vld[c], exp_done[c]} ||
                (exp_vld[c] && obs_s[c] !== {4'h0, 12'(exp_s1[c]), 4'h0, 12'(exp_s0[c])})) begin
                errors++;
                $display("[TB] FAIL wrap cyc %0d vld/done=%b%b smp=%h wanted %b%b", c, obs_vld[c], obs_done[c], obs_s[c], exp_vld[c], exp_done[c]);
            end
        end
        checks++;
        if (strobes != 8192 || obs_done[t + 8193] !== 1'b1) begin
            errors++; $display("[TB] FAIL wrap_count got %0d strobes done=%b want 8192 1", strobes, obs_done[t + 8193]);
        end
    endtask

    task automatic test_random();
        int len, a, t, n;
        logic [31:0] hold;
        for (int it = 0; it < 8; it++) begin
            do_reset(); prep();
            a = $urandom_range(1, 4);
            cfg_mode = $urandom_range(0, 3); cfg_ch = $urandom_range(0, 1);
            cfg_level = $urandom_range(0, 4095); cfg_hyst = $urandom_range(0, 300);
            cfg_dec = $urandom_range(0, 10); cfg_avg = $urandom_range(0, 1);
            cfg_num = $urandom_range(1, 3);
            n = 1 << ((cfg_dec > 8) ? 8 : cfg_dec);
            len = a + 100 + cfg_num * n + 5;
            arm_at(a);
            t = model_capture(a, len - 1);
            run(len);
            hold = '0;
            for (int c = 0; c < len; c++) begin
                if (exp_vld[c]) hold = {4'h0, 12'(exp_s1[c]), 4'h0, 12'(exp_s0[c])};
                checks++;
                if ({obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c]} !== {exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c]} || obs_s[c] !== hold) begin
                    errors++;
                    $display("[TB] FAIL rand%0d m%0d d%0d cyc %0d vtad=%b%b%b%b smp=%h wanted vtad=%b%b%b%b smp=%h", it, cfg_mode, cfg_dec, c, obs_vld[c], obs_trig[c], obs_armed[c], obs_done[c], obs_s[c], exp_vld[c], exp_trig[c], exp_armed[c], exp_done[c], hold);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(); prep();
        cfg_mode = 0; cfg_ch = 0; cfg_level = 0; cfg_hyst = 0; cfg_dec = 3; cfg_avg = 1; cfg_num = 8;
        arm_at(2);
        run(14);
        #2 sys_rst_n = 1'b0;
        #1;
        arm_i = 1'b0;
        checks++;
        if ({sample_vld_o, trig_o, armed_o, done_o} !== 4'b0000 || sample_o !== 32'h0) begin
            errors++; $display("[TB] FAIL midrst_async got vtad=%b%b%b%b smp=%h want all 0", sample_vld_o, trig_o, armed_o, done_o, sample_o);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            checks++;
            if ({sample_vld_o, trig_o, armed_o, done_o} !== 4'b0000 || sample_o !== 32'h0) begin
                errors++; $display("[TB] FAIL midrst_idle cyc %0d got vtad=%b%b%b%b smp=%h want all 0", c, sample_vld_o, trig_o, armed_o, done_o, sample_o);
            end
        end
        arm_i = 1'b1;
        @(negedge sys_clk);
        checks++;
        if (armed_o !== 1'b1) begin errors++; $display("[TB] FAIL midrst_rearm got armed=%b want 1", armed_o); end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_rise();
        test_average();
        test_fall();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
